sw_debounce4: RTL and testbench

SW_DEBOUNCE4 -- requirements
Module: sw_debounce4

---
 rtl/sw_debounce4_if.sv | 22 ++
 rtl/sw_debounce4.sv | 108 ++++++++++
 tb/tb_sw_debounce4.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sw_debounce4_if.sv
// Bus between the debouncer and its user: raw switches and tick in,
// debounced levels and change strobe out.
interface sw_debounce4_if;
    logic [3:0] sw_in;
    logic       tick;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       changed;
    logic [3:0] change_mask;

    modport master (
        output sw_in, tick,
        input  a, b, c, d, changed, change_mask
    );

    modport slave (
        input  sw_in, tick,
        output a, b, c, d, changed, change_mask
    );
endinterface

// File: rtl/sw_debounce4.sv
// Four-channel switch debouncer: two-flop synchronizers, a STABLE/CHECK FSM
// and tick-qualified counter per channel, plus a registered change strobe.
module sw_debounce4 #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    sw_debounce4_if.slave  bus
);
    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_e;

    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];
    logic [NCH-1:0] out_q;
    logic [NCH-1:0] out_d;
    logic [NCH-1:0] accept_c;
    logic           changed_q;
    logic [NCH-1:0] mask_q;

    // Metastability guard: only sync2_q is seen by the channel logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.sw_in;
            sync2_q <= sync1_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
            out_q     <= '0;
            changed_q <= 1'b0;
            mask_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            out_q     <= out_d;
            changed_q <= |accept_c;
            mask_q    <= accept_c;
        end
    end

    // Next-state logic.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                STABLE: begin
                    if (sync2_q[i] != out_q[i]) state_d[i] = CHECK;
                end
                CHECK: begin
                    if (sync2_q[i] == out_q[i]) begin
                        state_d[i] = STABLE;
                    end else if (bus.tick && (cnt_q[i] == CNT_LAST)) begin
                        state_d[i] = STABLE;
                    end
                end
                default: state_d[i] = STABLE;
            endcase
        end
    end

    // Counter, level and acceptance logic; a bounce always clears the count.
    always_comb begin
        out_d    = out_q;
        accept_c = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if ((state_q[i] == CHECK) && (sync2_q[i] != out_q[i])) begin
                if (!bus.tick) begin
                    cnt_d[i] = cnt_q[i];
                end else if (cnt_q[i] == CNT_LAST) begin
                    out_d[i]    = sync2_q[i];
                    accept_c[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign bus.a           = out_q[3];
    assign bus.b           = out_q[2];
    assign bus.c           = out_q[1];
    assign bus.d           = out_q[0];
    assign bus.changed     = changed_q;
    assign bus.change_mask = mask_q;
endmodule

// File: tb/tb_sw_debounce4.sv
// Bench for sw_debounce4: directed scenarios then random switching, with
// default (4) and minimum (1) debounce lengths against a tick-count model.
module tb_sw_debounce4;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       tk;
    int         checks = 0;
    int         errors = 0;

    sw_debounce4_if if0 ();
    sw_debounce4_if if1 ();

    assign if0.sw_in = sw;
    assign if0.tick  = tk;
    assign if1.sw_in = sw;
    assign if1.tick  = tk;

    always #5 clk = ~clk;

    sw_debounce4 #(.DEBOUNCE_CYCLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if0.slave));
    sw_debounce4 #(.DEBOUNCE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Model: a channel accepts once N tick edges have passed since it first
    // saw a differing synchronized level without that level ever bouncing back.
    logic [3:0] m_s1, m_s2;
    logic [3:0] m_out  [2];
    logic [3:0] m_pend [2];
    int         m_start[2][4];
    logic       m_chg  [2];
    logic [3:0] m_mask [2];
    int         m_tt = 0;

    function automatic int n_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    task automatic model_edge();
        logic [3:0] s2_old;
        logic [3:0] acc;
        int         tt_after;
        s2_old = m_s2;
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            for (int u = 0; u < 2; u++) begin
                m_out[u]  = '0;
                m_pend[u] = '0;
                m_chg[u]  = 1'b0;
                m_mask[u] = '0;
            end
        end else begin
            tt_after = m_tt + (tk ? 1 : 0);
            for (int u = 0; u < 2; u++) begin
                acc = '0;
                for (int i = 0; i < 4; i++) begin
                    if (!m_pend[u][i]) begin
                        if (s2_old[i] != m_out[u][i]) begin
                            m_pend[u][i]  = 1'b1;
                            m_start[u][i] = tt_after;
                        end
                    end else if (s2_old[i] == m_out[u][i]) begin
                        m_pend[u][i] = 1'b0;
                    end else if (tt_after - m_start[u][i] == n_of(u)) begin
                        m_out[u][i]  = s2_old[i];
                        m_pend[u][i] = 1'b0;
                        acc[i]       = 1'b1;
                    end
                end
                m_chg[u]  = |acc;
                m_mask[u] = acc;
            end
            m_tt = tt_after;
            m_s2 = m_s1;
            m_s1 = sw;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("n4_levels",  {if0.a, if0.b, if0.c, if0.d}, m_out[0]);
        chk("n4_changed", {3'b000, if0.changed}, {3'b000, m_chg[0]});
        chk("n4_mask",    if0.change_mask, m_mask[0]);
        chk("n1_levels",  {if1.a, if1.b, if1.c, if1.d}, m_out[1]);
        chk("n1_changed", {3'b000, if1.changed}, {3'b000, m_chg[1]});
        chk("n1_mask",    if1.change_mask, m_mask[1]);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        sw  = 4'b0000;
        tk  = 1'b1;
        rst = 1'b1;
        run(2);
        chk("reset_levels",  {if0.a, if0.b, if0.c, if0.d}, 4'b0000);
        chk("reset_changed", {3'b000, if0.changed}, 4'b0000);
        chk("reset_mask",    if0.change_mask, 4'b0000);
        rst = 1'b0;

        // Idle: no change pulse over 20 cycles.
        for (int j = 0; j < 20; j++) begin
            step();
            chk("idle_changed", {3'b000, if0.changed}, 4'b0000);
        end

        // Single channel latency: first sampling edge is step 1, accept at step 7.
        sw = 4'b1000;
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("a_latency_low", {if0.a, if0.b, if0.c, if0.d}, 4'b0000);
        end
        step();
        chk("a_accept_levels",  {if0.a, if0.b, if0.c, if0.d}, 4'b1000);
        chk("a_accept_changed", {3'b000, if0.changed}, 4'b0001);
        chk("a_accept_mask",    if0.change_mask, 4'b1000);
        step();
        chk("a_pulse_width", {3'b000, if0.changed}, 4'b0000);
        chk("a_mask_clear",  if0.change_mask, 4'b0000);
        sw = 4'b0000;
        run(10);

        // Bounce on D shorter than the window is discarded.
        sw = 4'b0001;
        run(3);
        sw = 4'b0000;
        for (int j = 0; j < 10; j++) begin
            step();
            chk("bounce_no_change", {3'b000, if0.changed}, 4'b0000);
        end
        sw = 4'b0001;
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("d_latency_low", {3'b000, if0.d}, 4'b0000);
        end
        step();
        chk("d_accept", {3'b000, if0.d}, 4'b0001);
        sw = 4'b0000;
        run(10);

        // Simultaneous acceptance on A and B.
        sw = 4'b1100;
        run(6);
        step();
        chk("ab_levels",  {if0.a, if0.b, if0.c, if0.d}, 4'b1100);
        chk("ab_changed", {3'b000, if0.changed}, 4'b0001);
        chk("ab_mask",    if0.change_mask, 4'b1100);
        sw = 4'b0000;
        run(10);

        // Sparse tick: counter holds between ticks.
        sw = 4'b0010;
        for (int j = 0; j < 30; j++) begin
            tk = (j % 3 == 0);
            step();
        end
        chk("sparse_tick_c", {3'b000, if0.c}, 4'b0001);
        tk = 1'b1;
        sw = 4'b0000;
        run(12);

        // Reset two ticks into CHECK abandons the pending acceptance.
        sw = 4'b0010;
        run(5);
        chk("pre_reset_c", {3'b000, if0.c}, 4'b0000);
        rst = 1'b1;
        step();
        chk("reset_mid_changed", {3'b000, if0.changed}, 4'b0000);
        chk("reset_mid_c",       {3'b000, if0.c}, 4'b0000);
        rst = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("post_reset_c_low", {3'b000, if0.c}, 4'b0000);
        end
        step();
        chk("post_reset_c",       {3'b000, if0.c}, 4'b0001);
        chk("post_reset_changed", {3'b000, if0.changed}, 4'b0001);
        chk("post_reset_mask",    if0.change_mask, 4'b0010);

        // Random switching with bounces, sparse ticks and occasional resets.
        for (int j = 0; j < 600; j++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) sw[i] = ~sw[i];
            end
            tk  = ($urandom_range(3) != 0);
            rst = ($urandom_range(99) == 0);
            step();
        end
        rst = 1'b0;
        run(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
